// File: rtl/arbitro_rr_4.sv
`default_nettype none
// ============================================================================
// arbitro_rr_4 : 4-way round-robin arbiter with registered grant and hold limit
// Rev 1.0
// ============================================================================
module arbitro_rr_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_v,
  output logic       preempt
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;

  localparam bit               LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_idx_q, gnt_idx_d;
  logic             gnt_v_q, gnt_v_d;
  logic             preempt_q, preempt_d;

  logic [1:0]       owner;
  logic [3:0]       others;
  logic [2:0]       win_idle;
  logic [2:0]       win_other;
  logic [1:0]       sel;
  logic             take_preempt;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = start + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign owner     = gnt_idx_q;
  assign others    = req & ~(4'b0001 << owner);
  assign win_idle  = rr_pick(req, ptr_q);
  assign win_other = rr_pick(others, owner + 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_q      <= 4'd0;
      gnt_idx_q  <= 2'd0;
      gnt_v_q    <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_v_q    <= gnt_v_d;
      preempt_q  <= preempt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    sel          = owner;
    take_preempt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_idle[2]) begin
          state_d    = ST_BUSY;
          sel        = win_idle[1:0];
          hold_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (!req[owner]) begin
          ptr_d      = owner + 2'd1;
          hold_cnt_d = '0;
          sel        = win_other[1:0];
          state_d    = win_other[2] ? ST_BUSY : ST_IDLE;
        end else if (LIMIT_EN && (hold_cnt_q == HOLD_LAST)) begin
          // At the limit a lone owner simply restarts its count.
          hold_cnt_d = '0;
          if (win_other[2]) begin
            ptr_d        = owner + 2'd1;
            sel          = win_other[1:0];
            take_preempt = 1'b1;
          end
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ptr_d      = 2'd0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    gnt_d     = 4'd0;
    gnt_idx_d = 2'd0;
    gnt_v_d   = 1'b0;
    preempt_d = 1'b0;
    if (state_d == ST_BUSY) begin
      gnt_d     = 4'b0001 << sel;
      gnt_idx_d = sel;
      gnt_v_d   = 1'b1;
      preempt_d = take_preempt;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_v   = gnt_v_q;
  assign preempt = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_4.sv
`default_nettype none
// ============================================================================
// tb_arbitro_rr_4 : directed and randomized checks of arbitro_rr_4
// Rev 1.0
// ============================================================================
module tb_arbitro_rr_4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'd0;

  logic [3:0] gnt4, gnt16;
  logic [1:0] idx4, idx16;
  logic       v4, v16, pre4, pre16;
  logic [7:0] obs4, obs16;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  arbitro_rr_4 #(.MAX_HOLD(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_v(v4), .preempt(pre4)
  );

  arbitro_rr_4 u_dut16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt16), .gnt_idx(idx16), .gnt_v(v16), .preempt(pre16)
  );

  assign obs4  = {gnt4, idx4, v4, pre4};
  assign obs16 = {gnt16, idx16, v16, pre16};

  // Reference model: owner (-1 = none), rotating start, cycles the owner has held.
  typedef struct packed {
    int   owner;
    int   ptr;
    int   held;
    logic pre;
  } mstate_t;

  mstate_t m4, m16;

  function automatic int pick(input logic [3:0] r, input int start);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = (start + i) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic mstate_t model_step(input int maxh, input logic [3:0] r, input mstate_t s);
    mstate_t    n;
    logic [3:0] rest;
    n     = s;
    n.pre = 1'b0;
    if (s.owner < 0) begin
      n.owner = pick(r, s.ptr);
      n.held  = 1;
    end else if (!r[s.owner]) begin
      n.ptr   = (s.owner + 1) % 4;
      n.owner = pick(r, n.ptr);
      n.held  = 1;
    end else if (maxh != 0 && s.held >= maxh) begin
      rest           = r;
      rest[s.owner]  = 1'b0;
      n.held         = 1;
      if (rest != 4'd0) begin
        n.ptr   = (s.owner + 1) % 4;
        n.owner = pick(rest, n.ptr);
        n.pre   = 1'b1;
      end
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] expect_obs(input mstate_t s);
    logic [3:0] g;
    if (s.owner < 0) return 8'h00;
    g = 4'b0001 << s.owner;
    return {g, 2'(s.owner), 1'b1, s.pre};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4  <= '{owner: -1, ptr: 0, held: 0, pre: 1'b0};
      m16 <= '{owner: -1, ptr: 0, held: 0, pre: 1'b0};
    end else begin
      m4  <= model_step(4, req, m4);
      m16 <= model_step(0 + 16, req, m16);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (obs4 !== 8'h00) $display("FAIL reset_dut4: got %b expected %b", obs4, 8'h00); else passed++;
    checks++; if (obs16 !== 8'h00) $display("FAIL reset_dut16: got %b expected %b", obs16, 8'h00); else passed++;
    rst_n = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    checks++; if (obs4 !== {4'b0100, 2'd2, 1'b1, 1'b0}) $display("FAIL first_grant_dut4: got %b expected %b", obs4, {4'b0100, 2'd2, 1'b1, 1'b0}); else passed++;
    checks++; if (obs16 !== {4'b0100, 2'd2, 1'b1, 1'b0}) $display("FAIL first_grant_dut16: got %b expected %b", obs16, {4'b0100, 2'd2, 1'b1, 1'b0}); else passed++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs4 !== 8'h00) $display("FAIL async_reset_dut4: got %b expected %b", obs4, 8'h00); else passed++;
    checks++; if (obs16 !== 8'h00) $display("FAIL async_reset_dut16: got %b expected %b", obs16, 8'h00); else passed++;
    req = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (obs4 !== 8'h00) $display("FAIL idle_after_reset_dut4: got %b expected %b", obs4, 8'h00); else passed++;
  endtask

  task automatic test_fairness();
    logic [7:0] e;
    req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      e = {4'(1 << o), 2'(o), 1'b1, 1'b0};
      checks++; if (obs4 !== e) $display("FAIL fair_order_dut4 step %0d: got %b expected %b", k, obs4, e); else passed++;
      checks++; if (obs16 !== e) $display("FAIL fair_order_dut16 step %0d: got %b expected %b", k, obs16, e); else passed++;
      if (k < 4) begin
        repeat (2) begin
          @(negedge clk);
          checks++; if (obs4 !== e) $display("FAIL fair_hold_dut4 step %0d: got %b expected %b", k, obs4, e); else passed++;
        end
        req[o] = 1'b0;
        @(negedge clk);
        req[o] = 1'b1;
      end
    end
  endtask

  task automatic test_handover();
    req = 4'd0;
    @(negedge clk);
    checks++; if (obs4 !== 8'h00) $display("FAIL release_idle_dut4: got %b expected %b", obs4, 8'h00); else passed++;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (obs16 !== {4'b0001, 2'd0, 1'b1, 1'b0}) $display("FAIL solo_grant_dut16: got %b expected %b", obs16, {4'b0001, 2'd0, 1'b1, 1'b0}); else passed++;
    req = 4'd0;
    @(negedge clk);
    checks++; if (obs4 !== 8'h00) $display("FAIL solo_release_dut4: got %b expected %b", obs4, 8'h00); else passed++;
    checks++; if (obs16 !== 8'h00) $display("FAIL solo_release_dut16: got %b expected %b", obs16, 8'h00); else passed++;
    req = 4'b0010;
    @(negedge clk);
    checks++; if (obs4 !== {4'b0010, 2'd1, 1'b1, 1'b0}) $display("FAIL regrant_dut4: got %b expected %b", obs4, {4'b0010, 2'd1, 1'b1, 1'b0}); else passed++;
  endtask

  task automatic test_preempt();
    logic [7:0] e;
    int         o;
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      o = ((c - 1) / 4) % 2;
      e = {4'(1 << o), 2'(o), 1'b1, (c > 1 && (c - 1) % 4 == 0)};
      checks++; if (obs4 !== e) $display("FAIL preempt_dut4 cyc %0d: got %b expected %b", c, obs4, e); else passed++;
      checks++; if (obs16 !== {4'b0001, 2'd0, 1'b1, 1'b0}) $display("FAIL no_preempt_dut16 cyc %0d: got %b expected %b", c, obs16, {4'b0001, 2'd0, 1'b1, 1'b0}); else passed++;
    end
  endtask

  task automatic test_sole_holder();
    do_reset();
    req = 4'b1000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++; if (obs4 !== {4'b1000, 2'd3, 1'b1, 1'b0}) $display("FAIL sole_holder_dut4 cyc %0d: got %b expected %b", c, obs4, {4'b1000, 2'd3, 1'b1, 1'b0}); else passed++;
    end
  endtask

  task automatic test_random();
    int         wait_n [4];
    logic [3:0] prev_g;
    logic [3:0] sampled;
    do_reset();
    for (int j = 0; j < 4; j++) wait_n[j] = 0;
    prev_g = 4'd0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      sampled = req;
      checks++; if (obs4 !== expect_obs(m4)) $display("FAIL rand_model_dut4 cyc %0d: got %b expected %b", c, obs4, expect_obs(m4)); else passed++;
      checks++; if (obs16 !== expect_obs(m16)) $display("FAIL rand_model_dut16 cyc %0d: got %b expected %b", c, obs16, expect_obs(m16)); else passed++;
      checks++;
      if (!$onehot0(gnt4) || (gnt4 != 4'd0 && !gnt4[idx4]) || (gnt4 == 4'd0 && idx4 != 2'd0) || (v4 != |gnt4))
        $display("FAIL rand_onehot_dut4 cyc %0d: got gnt=%b idx=%0d v=%b", c, gnt4, idx4, v4);
      else passed++;
      if (gnt4 != 4'd0 && gnt4 != prev_g) begin
        for (int j = 0; j < 4; j++) begin
          if (sampled[j] && !gnt4[j]) begin
            wait_n[j]++;
            checks++; if (wait_n[j] > 3) $display("FAIL rand_starve req %0d cyc %0d: got %0d grants passed expected at most 3", j, c, wait_n[j]); else passed++;
          end
        end
      end
      for (int j = 0; j < 4; j++) if (!sampled[j] || gnt4[j]) wait_n[j] = 0;
      prev_g = gnt4;
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 7) == 0) req[j] = ~req[j];
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_handover();
    test_preempt();
    test_sole_holder();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
